// File: rtl/bsg_mcl_axil_pkg.sv
// Shared definitions for the host-to-manycore AXI4-Lite register front-end:
// register offsets, AXI response codes and the write/read FSM state encodings.
package bsg_mcl_axil_pkg;

  localparam int OFF_W = 5;

  localparam logic [OFF_W-1:0] TDR_OFF    = 5'h00;
  localparam logic [OFF_W-1:0] TDFV_OFF   = 5'h04;
  localparam logic [OFF_W-1:0] RDR_OFF    = 5'h08;
  localparam logic [OFF_W-1:0] STAT_OFF   = 5'h0C;
  localparam logic [OFF_W-1:0] ERRCNT_OFF = 5'h10;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

endpackage

// File: rtl/bsg_mcl_axil_aw_w_join.sv
// Captures the AXI-Lite AW and W channels independently and presents one joined
// valid with offset, data and strobe held until the write FSM consumes them.
module bsg_mcl_axil_aw_w_join
  import bsg_mcl_axil_pkg::*;
#(
  parameter int axil_addr_width_p = 32,
  parameter int axil_data_width_p = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [axil_addr_width_p-1:0] awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [axil_data_width_p-1:0] wdata,
  input  logic [3:0]                   wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic                         consume,
  output logic                         join_v,
  output logic [OFF_W-1:0]             off,
  output logic [axil_data_width_p-1:0] data,
  output logic [3:0]                   strb
);

  logic                         en_r;
  logic                         aw_held_r;
  logic                         w_held_r;
  logic [OFF_W-1:0]             off_r;
  logic [axil_data_width_p-1:0] data_r;
  logic [3:0]                   strb_r;
  logic                         aw_fire;
  logic                         w_fire;
  logic                         unused_addr_hi;

  assign unused_addr_hi = ^awaddr[axil_addr_width_p-1:OFF_W];

  // Readies stay low until the first edge after reset, then track the hold flags.
  assign awready = en_r & ~aw_held_r;
  assign wready  = en_r & ~w_held_r;
  assign aw_fire = awready & awvalid;
  assign w_fire  = wready & wvalid;

  // Joined valid looks through the current handshakes so the FSM can leave idle
  // on the same edge that completes the later channel.
  assign join_v = (aw_held_r | aw_fire) & (w_held_r | w_fire);
  assign off    = off_r;
  assign data   = data_r;
  assign strb   = strb_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r      <= 1'b0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      en_r <= 1'b1;
      if (consume) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
      end else begin
        if (aw_fire) aw_held_r <= 1'b1;
        if (w_fire)  w_held_r  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_fire) off_r <= awaddr[OFF_W-1:0];
    if (w_fire) begin
      data_r <= wdata;
      strb_r <= wstrb;
    end
  end

endmodule

// File: rtl/bsg_mcl_axil_slave_regs.sv
// AXI4-Lite slave register front-end of the host-to-manycore link: TDR pushes request
// words, RDR pops response words. Define BSG_MCL_AXIL_ERR_CNT_EN to add ERRCNT at 0x10.
module bsg_mcl_axil_slave_regs
  import bsg_mcl_axil_pkg::*;
#(
  parameter int axil_addr_width_p   = 32,
  parameter int axil_data_width_p   = 32,
  parameter int req_credits_width_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [3:0]                     s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,
  output logic [31:0]                    axil_req_o,
  output logic                           axil_req_v_o,
  input  logic                           axil_req_ready_i,
  input  logic [31:0]                    axil_rsp_i,
  input  logic                           axil_rsp_v_i,
  output logic                           axil_rsp_yumi_o,
  input  logic [req_credits_width_p-1:0] req_credits_i
);

  w_state_e                     w_state_r;
  logic                         bvalid_r;
  axil_resp_e                   bresp_r;
  axil_resp_e                   w_resp;
  logic                         w_exec;
  logic                         j_v;
  logic [OFF_W-1:0]             w_off;
  logic [axil_data_width_p-1:0] w_data;
  logic [3:0]                   w_strb;

  r_state_e                     r_state_r;
  logic                         arready_r;
  logic                         rvalid_r;
  logic [31:0]                  rdata_r;
  axil_resp_e                   rresp_r;
  logic                         ar_fire;
  logic [OFF_W-1:0]             r_off;
  logic [31:0]                  rd_data_n;
  axil_resp_e                   rd_resp_n;
  logic                         unused_araddr_hi;

`ifdef BSG_MCL_AXIL_ERR_CNT_EN
  logic [15:0] err_cnt_r;
  logic [1:0]  err_inc;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
`endif

  function automatic axil_resp_e wr_resp(input logic [OFF_W-1:0] off,
                                         input logic [3:0] strb, input logic ready);
    case (off)
      TDR_OFF:                     return (strb == 4'hF && ready) ? OKAY : SLVERR;
      TDFV_OFF, RDR_OFF, STAT_OFF: return OKAY;
`ifdef BSG_MCL_AXIL_ERR_CNT_EN
      ERRCNT_OFF:                  return OKAY;
`endif
      default:                     return DECERR;
    endcase
  endfunction

  bsg_mcl_axil_aw_w_join #(
    .axil_addr_width_p(axil_addr_width_p),
    .axil_data_width_p(axil_data_width_p)
  ) aw_w_join (
    .clk    (clk_i),
    .reset_n(reset_n_i),
    .awaddr (s_axil_awaddr_i),
    .awvalid(s_axil_awvalid_i),
    .awready(s_axil_awready_o),
    .wdata  (s_axil_wdata_i),
    .wstrb  (s_axil_wstrb_i),
    .wvalid (s_axil_wvalid_i),
    .wready (s_axil_wready_o),
    .consume(w_exec),
    .join_v (j_v),
    .off    (w_off),
    .data   (w_data),
    .strb   (w_strb)
  );

  // Write path: a push is offered only in W_EXEC, and only when the FIFO is already ready.
  assign w_exec          = (w_state_r == W_EXEC);
  assign w_resp          = wr_resp(w_off, w_strb, axil_req_ready_i);
  assign axil_req_v_o    = w_exec & (w_off == TDR_OFF) & (w_strb == 4'hF) & axil_req_ready_i;
  assign axil_req_o      = w_exec ? w_data : '0;
  assign s_axil_bvalid_o = bvalid_r;
  assign s_axil_bresp_o  = bresp_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_state_r <= W_IDLE;
      bvalid_r  <= 1'b0;
      bresp_r   <= OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: if (j_v) w_state_r <= W_EXEC;
        W_EXEC: begin
          bvalid_r  <= 1'b1;
          bresp_r   <= w_resp;
          w_state_r <= W_RESP;
        end
        W_RESP: if (s_axil_bready_i) begin
          bvalid_r  <= 1'b0;
          w_state_r <= W_IDLE;
        end
        default: w_state_r <= W_IDLE;
      endcase
    end
  end

  // Read path: decode at the AR handshake; an RDR pop is tied to that same cycle.
  assign unused_araddr_hi = ^s_axil_araddr_i[axil_addr_width_p-1:OFF_W];
  assign r_off            = s_axil_araddr_i[OFF_W-1:0];
  assign ar_fire          = arready_r & s_axil_arvalid_i;
  assign axil_rsp_yumi_o  = ar_fire & (r_off == RDR_OFF) & axil_rsp_v_i;
  assign s_axil_arready_o = arready_r;
  assign s_axil_rvalid_o  = rvalid_r;
  assign s_axil_rdata_o   = rdata_r;
  assign s_axil_rresp_o   = rresp_r;

  always_comb begin
    rd_data_n = '0;
    rd_resp_n = OKAY;
    case (r_off)
      TDR_OFF:  rd_data_n = '0;
      TDFV_OFF: rd_data_n = 32'(req_credits_i);
      RDR_OFF:  if (axil_rsp_v_i) rd_data_n = axil_rsp_i;
                else rd_resp_n = SLVERR;
      STAT_OFF: rd_data_n = {30'b0, axil_req_ready_i, axil_rsp_v_i};
`ifdef BSG_MCL_AXIL_ERR_CNT_EN
      ERRCNT_OFF: rd_data_n = 32'(err_cnt_r);
`endif
      default:  rd_resp_n = DECERR;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= OKAY;
    end else begin
      case (r_state_r)
        R_IDLE: if (ar_fire) begin
          arready_r <= 1'b0;
          rvalid_r  <= 1'b1;
          rdata_r   <= rd_data_n;
          rresp_r   <= rd_resp_n;
          r_state_r <= R_RESP;
        end else begin
          arready_r <= 1'b1;
        end
        R_RESP: if (s_axil_rready_i) begin
          rvalid_r  <= 1'b0;
          arready_r <= 1'b1;
          r_state_r <= R_IDLE;
        end
        default: r_state_r <= R_IDLE;
      endcase
    end
  end

`ifdef BSG_MCL_AXIL_ERR_CNT_EN
  // Errors are counted when their response is accepted; both channels may add in one cycle.
  assign err_inc = {1'b0, bvalid_r & s_axil_bready_i & (bresp_r != OKAY)}
                 + {1'b0, rvalid_r & s_axil_rready_i & (rresp_r != OKAY)};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_cnt_r <= '0;
    else            err_cnt_r <= sat_add16(err_cnt_r, err_inc);
  end
`endif

endmodule

// File: tb/tb_bsg_mcl_axil_slave_regs.sv
// Directed bench for bsg_mcl_axil_slave_regs: register map, push/pop side effects,
// latencies, split AW/W timing and reset during an open write response.
module tb_bsg_mcl_axil_slave_regs;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata, req_o, rsp = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid, req_v, yumi;
  logic [3:0]  wstrb = 4'h0;
  logic [1:0]  bresp, rresp;
  logic        bready = 1'b1, rready = 1'b1, req_ready = 1'b1, rsp_v = 1'b0;
  logic [7:0]  credits = '0;

  int          n_chk = 0, n_pass = 0, cyc = 0;
  int          push_cnt = 0, pop_cnt = 0, viol = 0;
  logic [31:0] last_req = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_mcl_axil_slave_regs dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .axil_req_o(req_o), .axil_req_v_o(req_v), .axil_req_ready_i(req_ready),
    .axil_rsp_i(rsp), .axil_rsp_v_i(rsp_v), .axil_rsp_yumi_o(yumi),
    .req_credits_i(credits)
  );

  // Stream monitor samples mid-cycle, after the bench has settled its inputs.
  always begin
    @(negedge clk);
    #2;
    if (req_v && req_ready) begin push_cnt++; last_req = req_o; end
    if (yumi) pop_cnt++;
    if (yumi && !rsp_v) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_dly, output logic [1:0] resp, output int lat);
    int t, hs;
    logic aw_done, w_done, aw_f, w_f, got;
    aw_done = 0; w_done = 0; t = 0; hs = 0; resp = 2'b01; lat = -1;
    while (!(aw_done && w_done) && t < 100) begin
      @(negedge clk);
      if (t == 0) begin awaddr = a; awvalid = 1'b1; end
      if (t == w_dly) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      if (aw_f || w_f) hs = cyc;
      @(posedge clk);
      t++;
      #1;
      if (aw_f) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_f)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
    got = 0; t = 0;
    while (!got && t < 100) begin
      @(negedge clk);
      if (bvalid) begin got = 1; resp = bresp; lat = cyc - hs; end
      else t++;
    end
    chk("wr_bvalid_seen", 32'(got), 32'd1);
    if (got) begin @(posedge clk); #1; end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int t, hs;
    logic done, got;
    done = 0; t = 0; hs = 0; d = 32'hFFFF_FFFF; resp = 2'b01; lat = -1;
    while (!done && t < 100) begin
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      done = arready;
      hs = cyc;
      @(posedge clk);
      t++;
      #1;
    end
    arvalid = 1'b0;
    chk("rd_handshake", 32'(done), 32'd1);
    got = 0; t = 0;
    while (!got && t < 100) begin
      @(negedge clk);
      if (rvalid) begin got = 1; d = rdata; resp = rresp; lat = cyc - hs; end
      else t++;
    end
    chk("rd_rvalid_seen", 32'(got), 32'd1);
    if (got) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [1:0]  wr_r, rd_r;
    logic [31:0] rd_d;
    int          wr_l, rd_l, p0, t;
    logic        got;

    // Reset state and ready release
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({awready, wready, arready, bvalid, rvalid, req_v, yumi,
                            (|rdata), (|req_o), bresp, rresp}), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'({awready, wready, arready}), 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", 32'({awready, wready, arready}), 32'h7);

    // TDR push with FIFO ready
    p0 = push_cnt;
    axi_write(32'h0, 32'hDEADBEEF, 4'hF, 0, wr_r, wr_l);
    chk("tdr_bresp", 32'(wr_r), 32'h0);
    chk("tdr_push_cnt", 32'(push_cnt - p0), 32'd1);
    chk("tdr_word", last_req, 32'hDEADBEEF);
    chk("wr_latency", 32'(wr_l), 32'd2);

    // TDR with FIFO not ready, then with partial strobe
    req_ready = 1'b0;
    p0 = push_cnt;
    axi_write(32'h0, 32'h11111111, 4'hF, 0, wr_r, wr_l);
    chk("tdr_notready_bresp", 32'(wr_r), 32'h2);
    chk("tdr_notready_push", 32'(push_cnt - p0), 32'd0);
    req_ready = 1'b1;
    p0 = push_cnt;
    axi_write(32'h0, 32'h22222222, 4'h3, 0, wr_r, wr_l);
    chk("tdr_strb_bresp", 32'(wr_r), 32'h2);
    chk("tdr_strb_push", 32'(push_cnt - p0), 32'd0);

    // RDR pop with and without a response word
    rsp = 32'h12345678; rsp_v = 1'b1;
    p0 = pop_cnt;
    axi_read(32'h08, rd_d, rd_r, rd_l);
    chk("rdr_data", rd_d, 32'h12345678);
    chk("rdr_resp", 32'(rd_r), 32'h0);
    chk("rdr_pop_cnt", 32'(pop_cnt - p0), 32'd1);
    chk("rd_latency", 32'(rd_l), 32'd1);
    rsp_v = 1'b0;
    p0 = pop_cnt;
    axi_read(32'h08, rd_d, rd_r, rd_l);
    chk("rdr_empty_data", rd_d, 32'h0);
    chk("rdr_empty_resp", 32'(rd_r), 32'h2);
    chk("rdr_empty_pop", 32'(pop_cnt - p0), 32'd0);

    // TDFV, unmapped and misaligned offsets, TDR read
    credits = 8'd17;
    axi_read(32'h04, rd_d, rd_r, rd_l);
    chk("tdfv_data", rd_d, 32'h11);
    chk("tdfv_resp", 32'(rd_r), 32'h0);
    axi_read(32'h18, rd_d, rd_r, rd_l);
    chk("unmapped_resp", 32'(rd_r), 32'h3);
    chk("unmapped_data", rd_d, 32'h0);
    axi_read(32'h05, rd_d, rd_r, rd_l);
    chk("misaligned_resp", 32'(rd_r), 32'h3);
    axi_read(32'hFFFF_FF00, rd_d, rd_r, rd_l);
    chk("tdr_read_data", rd_d, 32'h0);
    chk("tdr_read_resp", 32'(rd_r), 32'h0);

    // Writes to non-TDR registers
    p0 = push_cnt;
    axi_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, wr_r, wr_l);
    chk("stat_write_bresp", 32'(wr_r), 32'h0);
    chk("stat_write_push", 32'(push_cnt - p0), 32'd0);
    axi_write(32'h1C, 32'h0, 4'hF, 0, wr_r, wr_l);
    chk("unmapped_write_bresp", 32'(wr_r), 32'h3);

    // AW three cycles ahead of W, with a concurrent STAT read
    p0 = push_cnt;
    fork
      axi_write(32'h0, 32'hCAFEF00D, 4'hF, 3, wr_r, wr_l);
      axi_read(32'h0C, rd_d, rd_r, rd_l);
    join
    chk("split_bresp", 32'(wr_r), 32'h0);
    chk("split_push_cnt", 32'(push_cnt - p0), 32'd1);
    chk("split_word", last_req, 32'hCAFEF00D);
    chk("split_wr_latency", 32'(wr_l), 32'd2);
    chk("stat_data", rd_d, 32'h2);
    chk("stat_resp", 32'(rd_r), 32'h0);

    axi_read(32'h10, rd_d, rd_r, rd_l);
`ifdef BSG_MCL_AXIL_ERR_CNT_EN
    chk("errcnt_resp", 32'(rd_r), 32'h0);
    chk("errcnt_value", rd_d, 32'd6);
`else
    chk("errcnt_absent_resp", 32'(rd_r), 32'h3);
`endif

    // Reset while a write response is pending
    bready = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", 32'({awready, wready}), 32'h3);
    awaddr = 32'h0; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    got = 0; t = 0;
    while (!got && t < 20) begin
      @(negedge clk);
      if (bvalid) got = 1;
      else t++;
    end
    chk("rst_bvalid_up", 32'(got), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_bvalid_drop", 32'(bvalid), 32'd0);
    chk("rst_ready_drop", 32'({awready, wready, arready, rvalid}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bready = 1'b1;
    @(posedge clk); #1;

`ifdef BSG_MCL_AXIL_ERR_CNT_EN
    axi_read(32'h10, rd_d, rd_r, rd_l);
    chk("errcnt_after_reset", rd_d, 32'd0);
    req_ready = 1'b0;
    axi_write(32'h0, 32'h1, 4'hF, 0, wr_r, wr_l);
    req_ready = 1'b1;
    axi_read(32'h18, rd_d, rd_r, rd_l);
    axi_read(32'h08, rd_d, rd_r, rd_l);
    axi_read(32'h10, rd_d, rd_r, rd_l);
    chk("errcnt_three", rd_d, 32'd3);
`endif

    // Post-reset sanity and pop protocol
    axi_read(32'h04, rd_d, rd_r, rd_l);
    chk("post_reset_tdfv", rd_d, 32'h11);
    chk("yumi_without_v", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
